// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg
//  Description : EX/MEM pipeline register. Captures the execute-stage results
//                and MEM/WB control bits, resolves branches into a single
//                PC-redirect pulse and runs a kill counter that squashes
//                wrong-path work upstream.
//                Optional build macro: MISALIGN_CHECK_EN (flags and suppresses
//                misaligned memory accesses).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_W       = 32,
    parameter int REGADDR_W    = 32,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    alu_res,
    input  logic                 zero_flag,
    input  logic [DATA_W-1:0]    branch_target,
    input  logic [REGADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0]    store_data,
    input  logic                 ctl_regwrite,
    input  logic                 ctl_memread,
    input  logic                 ctl_memwrite,
    input  logic                 ctl_memtoreg,
    input  logic                 ctl_branch,
    output logic [DATA_W-1:0]    q_alu_res,
    output logic [DATA_W-1:0]    q_store_data,
    output logic [REGADDR_W-1:0] q_wr_reg,
    output logic                 q_regwrite,
    output logic                 q_memread,
    output logic                 q_memwrite,
    output logic                 q_memtoreg,
    output logic                 out_valid,
    output logic                 pc_src,
    output logic [DATA_W-1:0]    pc_target,
    output logic                 kill_upstream,
    output logic                 misalign_err
);

    // Kill FSM encoding and counter sizing (FLUSH_CYCLES is at most 15).
    localparam int              c_CNT_W     = 4;
    localparam logic [0:0]      c_S_IDLE    = 1'b0;
    localparam logic [0:0]      c_S_KILL    = 1'b1;
    localparam logic [c_CNT_W-1:0] c_KILL_INIT = c_CNT_W'(FLUSH_CYCLES - 1);
    // A single-cycle flush is just the taken pulse; the KILL state is never used.
    localparam logic            c_HAS_KILL  = (FLUSH_CYCLES > 1);

    logic [DATA_W-1:0]    r_alu_res;
    logic [DATA_W-1:0]    r_store_data;
    logic [DATA_W-1:0]    r_branch_target;
    logic [REGADDR_W-1:0] r_wr_reg;
    logic                 r_zero;
    logic                 r_regwrite;
    logic                 r_memread;
    logic                 r_memwrite;
    logic                 r_memtoreg;
    logic                 r_branch;
    logic                 r_valid;
    logic                 r_consumed;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic                 w_taken;
    logic                 w_in_kill;
    logic                 w_bubble;
    logic                 w_mis;

    // consumed blocks a second redirect while a stalled branch is held.
    assign w_taken   = r_valid & r_branch & r_zero & ~r_consumed;
    assign w_in_kill = (r_state == c_S_KILL);
    assign w_bubble  = flush | ~in_valid | w_in_kill;

`ifdef MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_mis = (ctl_memread | ctl_memwrite) & (alu_res[1:0] != 2'b00);

    // Misalignment flag follows the entry: set on load, cleared by bubbles, held on stall.
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_misalign <= w_mis;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign w_mis        = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Pipeline entry: bubble beats stall, stall holds, otherwise capture EX.
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_alu_res       <= '0;
            r_store_data    <= '0;
            r_branch_target <= '0;
            r_wr_reg        <= '0;
            r_zero          <= 1'b0;
            r_regwrite      <= 1'b0;
            r_memread       <= 1'b0;
            r_memwrite      <= 1'b0;
            r_memtoreg      <= 1'b0;
            r_branch        <= 1'b0;
            r_valid         <= 1'b0;
            r_consumed      <= 1'b0;
        end else if (stall) begin
            r_consumed      <= r_consumed | w_taken;
        end else begin
            r_alu_res       <= alu_res;
            r_store_data    <= store_data;
            r_branch_target <= branch_target;
            r_wr_reg        <= wr_reg;
            r_zero          <= zero_flag;
            r_regwrite      <= ctl_regwrite & ~w_mis;
            r_memread       <= ctl_memread  & ~w_mis;
            r_memwrite      <= ctl_memwrite & ~w_mis;
            r_memtoreg      <= ctl_memtoreg;
            r_branch        <= ctl_branch;
            r_valid         <= 1'b1;
            r_consumed      <= 1'b0;
        end
    end

    // Kill FSM state register; counts independently of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Kill FSM next state: cnt holds the number of KILL cycles still to run.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (w_taken && c_HAS_KILL) begin
                    w_state_nxt = c_S_KILL;
                    w_cnt_nxt   = c_KILL_INIT;
                end
            end
            default: begin
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - c_CNT_W'(1);
                end
            end
        endcase
    end

    assign q_alu_res     = r_alu_res;
    assign q_store_data  = r_store_data;
    assign q_wr_reg      = r_wr_reg;
    assign q_regwrite    = r_regwrite & r_valid;
    assign q_memread     = r_memread  & r_valid;
    assign q_memwrite    = r_memwrite & r_valid;
    assign q_memtoreg    = r_memtoreg & r_valid;
    assign out_valid     = r_valid;
    assign pc_src        = w_taken;
    assign pc_target     = r_branch_target;
    assign kill_upstream = w_taken | w_in_kill;

endmodule
`default_nettype wire
